ctrl_in_trg: RTL

CTRL_IN_TRG -- requirements
Module: ctrl_in_trg

---
 rtl/ctrl_in_trg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ctrl_in_trg.sv
// Trigger input router: synchronizes external inputs and maps them onto start/stop/restart
// toggle and pulse outputs. Optional per-destination holdoff counters via CTRL_IN_HOLDOFF_EN.
module ctrl_in_trg #(
  parameter int REG_WIDTH    = 32,
  parameter int NUM_EXT      = 3,
  parameter int HOLDOFF_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [REG_WIDTH-1:0] ctrl_in0,
  input  logic [REG_WIDTH-1:0] ctrl_in1,
  input  logic [NUM_EXT-1:0]   ext_in,
  output logic [NUM_EXT-1:0]   ext_sync,
  output logic                 trg_start,
  output logic                 trg_stop,
  output logic                 trg_restart,
  output logic [2:0]           trg_pulse
);

  localparam int NUM_DST = 3;

  typedef enum logic [1:0] {
    LVL_FALL = 2'd0,
    LVL_RISE = 2'd1,
    LVL_LOW  = 2'd2,
    LVL_HIGH = 2'd3
  } level_e;

  logic [NUM_EXT-1:0] s1, s2, s3;
  logic [NUM_DST-1:0] cond;
  logic [NUM_DST-1:0] accept;
  logic [NUM_DST-1:0] toggle_q;
  logic [NUM_DST-1:0] pulse_q;

  // Reserved field bits and the upper register bits carry no function.
  logic unused_cfg;
  assign unused_cfg = ^{ctrl_in0, ctrl_in1};

  // s3 follows s2 unconditionally, so changing a source selection never fabricates an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= ext_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ext_sync = s2;

  always_comb begin
    logic [1:0] src;
    level_e     lvl;
    logic       cur;
    logic       prev;
    logic       src_ok;
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    cond = '0;
    src  = '0;
    lvl  = LVL_FALL;
    cur  = 1'b0;
    prev = 1'b0;
    src_ok = 1'b0;
    for (int d = 0; d < NUM_DST; d++) begin
      src    = ctrl_in0[8*d +: 2];
      lvl    = level_e'(ctrl_in0[8*d+2 +: 2]);
      cur    = 1'b0;
      prev   = 1'b0;
      src_ok = 1'b0;
      for (int e = 0; e < NUM_EXT; e++) begin
        if (int'(src) == e + 1) begin
          cur    = s2[e];
          prev   = s3[e];
          src_ok = 1'b1;
        end
      end
      if (src_ok) begin
        case (lvl)
          LVL_FALL: cond[d] = ~cur & prev;
          LVL_RISE: cond[d] = cur & ~prev;
          LVL_LOW:  cond[d] = ~cur;
          LVL_HIGH: cond[d] = cur;
          default:  cond[d] = 1'b0;
        endcase
      end
    end
  end

`ifdef CTRL_IN_HOLDOFF_EN
  logic [HOLDOFF_BITS-1:0] holdoff_val;
  logic [HOLDOFF_BITS-1:0] holdoff_q [NUM_DST];

  assign holdoff_val = ctrl_in1[HOLDOFF_BITS-1:0];

  always_comb begin
    accept = '0;
    for (int d = 0; d < NUM_DST; d++) begin
      accept[d] = cond[d] && (holdoff_q[d] == '0);
    end
  end

  // Counters reload to H on acceptance and count down to zero; events arriving meanwhile are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: this small counter array must be reset so an interrupted holdoff cannot survive reset.
    if (!reset_n) begin
      for (int d = 0; d < NUM_DST; d++) holdoff_q[d] <= '0;
    end else begin
      for (int d = 0; d < NUM_DST; d++) begin
        if (accept[d]) begin
          holdoff_q[d] <= holdoff_val;
        end else if (holdoff_q[d] != '0) begin
          holdoff_q[d] <= holdoff_q[d] - 1'b1;
        end
      end
    end
  end
`else
  assign accept = cond;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= '0;
      pulse_q  <= '0;
    end else begin
      toggle_q <= toggle_q ^ accept;
      pulse_q  <= accept;
    end
  end

  assign trg_start   = toggle_q[0];
  assign trg_stop    = toggle_q[1];
  assign trg_restart = toggle_q[2];
  assign trg_pulse   = pulse_q;

endmodule
